shift_unit_pipe: RTL
====================

SHIFT_UNIT_PIPE -- requirements
Module: shift_unit_pipe

Interface
REQ-001 Parameter XLEN, default 32, shifter data width; SHALL be a power of two and at least 8.
REQ-002 Parameter SHAMT_W, default $clog2(XLEN), shift-amount width and pipeline depth; SHALL NOT be overridden independently of XLEN.
REQ-003 Port i_clk, input, 1 bit, single clock; all state SHALL update on its rising edge.
REQ-004 Port i_rst_n, input, 1 bit, synchronous active-low reset.
REQ-005 Port i_valid, input, 1 bit, upstream operation valid.
REQ-006 Port o_ready, output, 1 bit, unit accepts an operation this cycle.
REQ-007 Port i_a, input, XLEN bits, operand to shift.
REQ-008 Port i_b, input, XLEN bits, shift amount; only i_b[SHAMT_W-1:0] SHALL be used.
REQ-009 Port i_op, input, 2 bits, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-010 Port o_valid, output, 1 bit, result valid.
REQ-011 Port i_ready, input, 1 bit, downstream accepts the result.
REQ-012 Port o_r, output, XLEN bits, shift result.
REQ-013 Port o_illegal, output, 1 bit, qualified by o_valid; the result came from an unsupported i_op.
REQ-014 Port o_busy, output, 1 bit, at least one pipeline stage holds a valid operation.

Function
REQ-015 The unit SHALL be a SHAMT_W-stage registered pipeline.
- Stage k conditionally shifts by 2^k when amount bit k is set.
- Each stage carries valid, op, the remaining amount bits, and data.
REQ-016 An operation SHALL be accepted on a cycle where i_valid && o_ready.
REQ-017 Latency from acceptance to o_valid SHALL be exactly SHAMT_W cycles when i_ready is held high; throughput SHALL be one operation per cycle.
REQ-018 Each stage SHALL advance when it is empty or the next stage advances; o_ready = ~valid_stage0 | advance_stage0.
REQ-019 Backpressure SHALL be lossless:
- While o_valid && !i_ready, o_r, o_illegal and o_valid SHALL hold stable.
- Bubbles SHALL collapse.
REQ-020 SLL and SRL SHALL fill vacated bits with 0.
REQ-021 SRA SHALL fill vacated bits with i_a[XLEN-1].
REQ-022 An amount of 0 SHALL return i_a unchanged for every op.
REQ-023 Operations SHALL retire in acceptance order, with no reordering and no duplication.
REQ-024 Simultaneous accept and retire in one cycle SHALL be supported with a full pipeline and sustain full throughput.
REQ-025 o_busy SHALL be the OR of all stage valid bits.

Reset
REQ-026 On a rising edge with i_rst_n=0, all stage valid bits SHALL clear and all data, op and amount registers SHALL load 0.
REQ-027 During reset, o_valid=0, o_busy=0, o_r=0, o_illegal=0 and o_ready=1.
REQ-028 Operations in flight when reset is asserted SHALL be discarded; none SHALL appear on o_valid after reset deasserts.
REQ-029 The first operation accepted after reset SHALL retire with the nominal SHAMT_W latency.

Configuration
REQ-030 Macro SHIFT_ROTATE_EN SHALL control rotate support.
- Defined: op 11 performs rotate-right by amount, and o_illegal is always 0.
- Not defined: op 11 produces o_r=0 with o_illegal=1 at normal latency, and no rotate datapath is synthesised.

Verification
REQ-031 Basic latency: XLEN=32, SLL a=0x0000_0001 b=31, i_ready=1 -> o_r=0x8000_0000 with o_valid exactly 5 cycles after accept.
REQ-032 Sign fill and masking:
- SRA a=0x8000_0000 b=4 -> o_r=0xF800_0000.
- SRL with the same inputs -> 0x0800_0000.
- b=0x0000_0024 (amount 4) gives the same results.
REQ-033 Rotate: ROR a=0x0000_00F1 b=4.
- With SHIFT_ROTATE_EN -> o_r=0x1000_000F, o_illegal=0.
- Without it -> o_r=0, o_illegal=1.
REQ-034 Backpressure:
- Issue 8 back-to-back SLL ops with amounts 0..7 on a=1 while i_ready is toggled pseudo-randomly.
- Expect results 1,2,4,...,128 in order, outputs stable while stalled, and o_ready=0 only when all 5 stages are full and i_ready=0.
REQ-035 Reset mid-flight: accept 3 ops, assert i_rst_n=0 for one cycle at cycle 2 -> no o_valid for those ops, o_busy=0, and the next op retires after 5 cycles.

Source files
------------

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA, optional ROR): stage k shifts by 2^k when amount bit k is set.
// Define SHIFT_ROTATE_EN to build the rotate datapath; otherwise op 11 retires as illegal with o_r=0.
module shift_unit_pipe #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  logic [1:0]      i_op,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_r,
  output logic            o_illegal,
  output logic            o_busy
);
  localparam int N = SHAMT_W;

  function automatic logic [XLEN-1:0] step(input logic [XLEN-1:0] d, input logic [1:0] op,
                                           input logic en, input int sh);
    logic signed [XLEN-1:0] ds;
    logic [XLEN-1:0]        r;
    ds = d;
    r  = d;
    case (op)
      2'b00:   if (en) r = d << sh;
      2'b01:   if (en) r = d >> sh;
      2'b10:   if (en) r = XLEN'(ds >>> sh);
      default: begin
`ifdef SHIFT_ROTATE_EN
        if (en) r = (d >> sh) | (d << (XLEN - sh));
`else
        // unsupported op: zeroed at stage 0 and carried as zero to the output
        r = '0;
`endif
      end
    endcase
    return r;
  endfunction

  logic [N:0]   adv;
  logic [N-1:0] vld_vec;

  assign adv[N] = i_ready;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic                vld_q, vld_d;
    logic [1:0]          op_q, op_d;
    logic [SHAMT_W-1:0]  amt_q, amt_d;
    logic [XLEN-1:0]     dat_q, dat_d;
    logic                src_vld;
    logic [1:0]          src_op;
    logic [SHAMT_W-1:0]  src_amt;
    logic [XLEN-1:0]     src_dat;

    if (k == 0) begin : g_in
      assign src_vld = i_valid;
      assign src_op  = i_op;
      assign src_amt = i_b[SHAMT_W-1:0];
      assign src_dat = i_a;
    end else begin : g_chain
      assign src_vld = g_stage[k-1].vld_q;
      assign src_op  = g_stage[k-1].op_q;
      assign src_amt = g_stage[k-1].amt_q;
      assign src_dat = g_stage[k-1].dat_q;
    end

    // a stage loads when empty or when its occupant moves on; empty sources load as bubbles
    assign adv[k]     = ~vld_q | adv[k+1];
    assign vld_vec[k] = vld_q;

    always_comb begin
      vld_d = vld_q;
      op_d  = op_q;
      amt_d = amt_q;
      dat_d = dat_q;
      if (adv[k]) begin
        vld_d = src_vld;
        op_d  = src_op;
        amt_d = src_amt;
        dat_d = step(src_dat, src_op, src_amt[k], 1 << k);
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        vld_q <= 1'b0;
        op_q  <= '0;
        amt_q <= '0;
        dat_q <= '0;
      end else begin
        vld_q <= vld_d;
        op_q  <= op_d;
        amt_q <= amt_d;
        dat_q <= dat_d;
      end
    end
  end

  // outputs are forced to their idle values while reset is held
  assign o_valid = i_rst_n & g_stage[N-1].vld_q;
  assign o_r     = i_rst_n ? g_stage[N-1].dat_q : '0;
  assign o_busy  = i_rst_n & (|vld_vec);
  assign o_ready = ~i_rst_n | adv[0];
`ifdef SHIFT_ROTATE_EN
  assign o_illegal = 1'b0;
`else
  assign o_illegal = i_rst_n & g_stage[N-1].vld_q & (g_stage[N-1].op_q == 2'b11);
`endif

endmodule
